// File: rtl/qbuff_pkg.sv
// Shared types and constants for the qbuff capture buffer.
package qbuff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CMP_GT = 1'b0;
  localparam logic CMP_LT = 1'b1;

endpackage

// File: rtl/qbuff_dly.sv
// Shift-register delay line: q is d delayed by DLY clock cycles, all bits together.
module qbuff_dly #(
  parameter int DLY = 19,
  parameter int W   = 64
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DLY];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DLY; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DLY-1];

endmodule

// File: rtl/qbuff.sv
// Qualified capture buffer: a threshold hit inside the trigger window writes NSAMP delayed words to RAM.
// Define QBUFF_ADDR_WRAP_EN to let the write address wrap instead of ending the capture at the top of memory.
module qbuff
  import qbuff_pkg::*;
#(
  parameter int DLY = 20,
  parameter int B   = 16,
  parameter int L   = 4,
  parameter int N   = 10
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [L*B-1:0]      din,
  input  logic                trigger,
  output logic                mem_we,
  output logic [N-1:0]        mem_addr,
  output logic [L*B-1:0]      mem_di,
  input  logic                COMP_MODE_REG,
  input  logic signed [B-1:0] COMP_THR_REG,
  input  logic                WMEM_START_REG,
  input  logic [N-1:0]        WMEM_ADDR_REG,
  input  logic [N-1:0]        WMEM_NSAMP_REG
);

  function automatic logic lane_hit(input logic [L*B-1:0] w, input logic mode,
                                    input logic signed [B-1:0] thr);
    logic signed [B-1:0] s;
    logic                hit;
    hit = 1'b0;
    for (int i = 0; i < L; i++) begin
      s = w[i*B +: B];
      if (mode == CMP_LT) hit = hit | (s < thr);
      else                hit = hit | (s > thr);
    end
    return hit;
  endfunction

  state_t                state, state_d;
  logic                  start_q, start_rise, load_cfg;
  logic                  hit_r, end_of_range;
  logic [N-1:0]          addr_r, addr_d, cnt_r, cnt_d;
  logic                  mode_sh;
  logic signed [B-1:0]   thr_sh;
  logic [N-1:0]          addr_sh, nsamp_sh;
  logic                  mode_eff;
  logic signed [B-1:0]   thr_eff;
  logic [L*B-1:0]        dly_q;

  // The mem_di register supplies the last delay stage, so the line itself is one shorter.
  qbuff_dly #(.DLY(DLY-1), .W(L*B)) u_dly (
    .aclk   (aclk),
    .areset (areset),
    .d      (din),
    .q      (dly_q)
  );

  // In IDLE the comparator follows the live registers so the cycle that arms already
  // compares with the values being latched; afterwards only the shadow copy counts.
  assign mode_eff   = (state == IDLE) ? COMP_MODE_REG : mode_sh;
  assign thr_eff    = (state == IDLE) ? COMP_THR_REG  : thr_sh;
  assign start_rise = WMEM_START_REG & ~start_q;

`ifdef QBUFF_ADDR_WRAP_EN
  assign end_of_range = 1'b0;
`else
  assign end_of_range = &addr_r;
`endif

  // ---- stage p0 -> p1: compare, delay-line tap, config shadows ----
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      start_q  <= 1'b1;
      hit_r    <= 1'b0;
      mem_di   <= '0;
      addr_r   <= '0;
      cnt_r    <= '0;
      mode_sh  <= CMP_GT;
      thr_sh   <= '0;
      addr_sh  <= '0;
      nsamp_sh <= '0;
    end else begin
      start_q <= WMEM_START_REG;
      hit_r   <= trigger & lane_hit(din, mode_eff, thr_eff);
      mem_di  <= dly_q;
      addr_r  <= addr_d;
      cnt_r   <= cnt_d;
      if (load_cfg) begin
        mode_sh  <= COMP_MODE_REG;
        thr_sh   <= COMP_THR_REG;
        addr_sh  <= WMEM_ADDR_REG;
        nsamp_sh <= WMEM_NSAMP_REG;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr_r;
    cnt_d    = cnt_r;
    load_cfg = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          load_cfg = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (!WMEM_START_REG) begin
          state_d = IDLE;
        end else if (hit_r) begin
          if (nsamp_sh == '0) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
            addr_d  = addr_sh;
            cnt_d   = nsamp_sh;
          end
        end
      end
      WRITE: begin
        if (!WMEM_START_REG) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_r + 1'b1;
          cnt_d  = cnt_r - 1'b1;
          if (cnt_r == N'(1) || end_of_range) state_d = DONE;
        end
      end
      DONE: begin
        if (!WMEM_START_REG) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: memory write port ----
  assign mem_we   = (state == WRITE);
  assign mem_addr = addr_r;

endmodule

// File: tb/tb_qbuff.sv
// Directed self-checking bench for qbuff; reference data comes from a per-cycle history of din.
module tb_qbuff;

  localparam int DLY = 20;
  localparam int B   = 16;
  localparam int L   = 4;
  localparam int N   = 10;
  localparam int W   = L * B;

  logic         aclk = 1'b0;
  logic         areset;
  logic [W-1:0] din;
  logic         trigger;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [W-1:0] mem_di;
  logic         mode;
  logic [B-1:0] thr;
  logic         start;
  logic [N-1:0] waddr;
  logic [N-1:0] nsamp;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [W-1:0] hist [0:4095];

  qbuff #(.DLY(DLY), .B(B), .L(L), .N(N)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .din            (din),
    .trigger        (trigger),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_di         (mem_di),
    .COMP_MODE_REG  (mode),
    .COMP_THR_REG   (thr),
    .WMEM_START_REG (start),
    .WMEM_ADDR_REG  (waddr),
    .WMEM_NSAMP_REG (nsamp)
  );

  always #5 aclk = ~aclk;

  // Background words: small non-negative lanes, never a hit for the thresholds used here.
  function automatic logic [W-1:0] bg(input int c);
    logic [W-1:0] w;
    for (int i = 0; i < L; i++) w[i*B +: B] = B'((c * 4 + i) % 2000);
    return w;
  endfunction

  function automatic logic [W-1:0] hitw(input int lane, input logic [B-1:0] v);
    logic [W-1:0] w;
    w = bg(cyc + 1);
    w[lane*B +: B] = v;
    return w;
  endfunction

  function automatic logic [W-1:0] pk(input logic [B-1:0] a, input logic [B-1:0] b,
                                      input logic [B-1:0] c, input logic [B-1:0] d);
    return {d, c, b, a};
  endfunction

  // Drives din for the next cycle and returns at mid-cycle, where outputs are sampled.
  task automatic tick(input logic [W-1:0] w);
    @(posedge aclk);
    #1;
    cyc++;
    din = w;
    hist[cyc % 4096] = w;
    @(negedge aclk);
  endtask

  task automatic tickb();
    tick(bg(cyc + 1));
  endtask

  task automatic arm(input logic m, input logic [B-1:0] t, input int a, input int n);
    mode  = m;
    thr   = t;
    waddr = N'(a);
    nsamp = N'(n);
    start = 1'b0;
    tickb();
    start = 1'b1;
    tickb();
    tickb();
  endtask

  task automatic test_reset();
    int nw;
    areset  = 1'b1;
    start   = 1'b1;
    trigger = 1'b1;
    mode    = 1'b0;
    thr     = 16'sd15000;
    waddr   = '0;
    nsamp   = 10'd4;
    din     = bg(0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", mem_we); end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
    checks++;
    if (mem_di !== '0) begin errors++; $display("FAIL reset_di got=%h want=0", mem_di); end
    areset = 1'b0;
    repeat (3) tickb();
    tick(hitw(2, 16'sd15500));
    nw = 0;
    for (int k = 0; k < 25; k++) begin
      tickb();
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL start_held_from_reset writes got=%0d want=0", nw); end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_gt_capture();
    int h, nw;
    logic [N-1:0] ea;
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 0, 39);
    tick(hitw(2, 16'sd15500));
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 45; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 40) begin
        ea = N'(cyc - h - 2);
        if (mem_we !== 1'b1 || mem_addr !== ea || mem_di !== hist[(cyc - DLY) % 4096]) begin
          errors++;
          $display("FAIL gt_write cyc=h+%0d we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   cyc - h, mem_we, mem_addr, mem_di, ea, hist[(cyc - DLY) % 4096]);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL gt_idle cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== 39) begin errors++; $display("FAIL gt_count got=%0d want=39", nw); end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_lt_capture();
    int h, nw;
    logic [N-1:0] ea;
    logic [W-1:0] pw;
    trigger = 1'b1;
    arm(1'b1, -16'sd2000, 5, 59);
    pw = pk(-16'sd2500, -16'sd2800, -16'sd2300, -16'sd1500);
    tick(pw);
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 64; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 60) begin
        ea = N'(5 + cyc - h - 2);
        if (mem_we !== 1'b1 || mem_addr !== ea || mem_di !== hist[(cyc - DLY) % 4096]) begin
          errors++;
          $display("FAIL lt_write cyc=h+%0d we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   cyc - h, mem_we, mem_addr, mem_di, ea, hist[(cyc - DLY) % 4096]);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL lt_idle cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== 59) begin errors++; $display("FAIL lt_count got=%0d want=59", nw); end
    tick(pw);
    nw = 0;
    for (int k = 0; k < 25; k++) begin
      tickb();
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL lt_second_pulse writes got=%0d want=0", nw); end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_no_hit();
    int h, nw;
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 100, 3);
    trigger = 1'b0;
    tick(hitw(2, 16'sd15500));
    nw = 0;
    repeat (5) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL no_trigger writes got=%0d want=0", nw); end
    trigger = 1'b1;
    tick(hitw(1, 16'sd15000));
    nw = 0;
    repeat (5) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL equal_thr writes got=%0d want=0", nw); end
    tick(hitw(0, 16'sd15001));
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 8; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 4) begin
        if (mem_we !== 1'b1 || mem_addr !== N'(100 + cyc - h - 2)) begin
          errors++;
          $display("FAIL still_armed cyc=h+%0d we=%b addr=%0d want we=1 addr=%0d",
                   cyc - h, mem_we, mem_addr, 100 + cyc - h - 2);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL still_armed_idle cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
    end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_abort_rearm();
    int h, nw;
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 200, 50);
    tick(hitw(3, 16'sd16000));
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 15; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 11) begin
        if (mem_we !== 1'b1 || mem_addr !== N'(200 + cyc - h - 2)) begin
          errors++;
          $display("FAIL abort_write cyc=h+%0d we=%b addr=%0d want we=1 addr=%0d",
                   cyc - h, mem_we, mem_addr, 200 + cyc - h - 2);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL abort_stop cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
      if (mem_we === 1'b1) nw++;
      if (cyc == h + 11) start = 1'b0;
    end
    checks++;
    if (nw !== 10) begin errors++; $display("FAIL abort_count got=%0d want=10", nw); end
    waddr = 10'd300;
    nsamp = 10'd4;
    start = 1'b1;
    tickb();
    waddr = 10'd700;
    nsamp = 10'd9;
    mode  = 1'b1;
    nw = 0;
    repeat (4) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL latched_mode writes got=%0d want=0", nw); end
    tick(hitw(0, 16'sd15100));
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 10; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 5) begin
        if (mem_we !== 1'b1 || mem_addr !== N'(300 + cyc - h - 2)) begin
          errors++;
          $display("FAIL rearm_write cyc=h+%0d we=%b addr=%0d want we=1 addr=%0d",
                   cyc - h, mem_we, mem_addr, 300 + cyc - h - 2);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rearm_idle cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== 4) begin errors++; $display("FAIL rearm_count got=%0d want=4", nw); end
    start = 1'b0;
    mode  = 1'b0;
    tickb();
  endtask

  task automatic test_addr_end();
    int h, nw, nexp;
`ifdef QBUFF_ADDR_WRAP_EN
    nexp = 8;
`else
    nexp = 4;
`endif
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 1020, 8);
    tick(hitw(2, 16'sd15500));
    h  = cyc;
    nw = 0;
    for (int k = 1; k <= 12; k++) begin
      tickb();
      checks++;
      if (cyc >= h + 2 && cyc <= h + 1 + nexp) begin
        if (mem_we !== 1'b1 || mem_addr !== N'(1020 + cyc - h - 2)) begin
          errors++;
          $display("FAIL addr_end_write cyc=h+%0d we=%b addr=%0d want we=1 addr=%0d",
                   cyc - h, mem_we, mem_addr, (1020 + cyc - h - 2) % 1024);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL addr_end_idle cyc=h+%0d we=%b want=0", cyc - h, mem_we);
      end
      if (mem_we === 1'b1) nw++;
    end
    checks++;
    if (nw !== nexp) begin errors++; $display("FAIL addr_end_count got=%0d want=%0d", nw, nexp); end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_nsamp_zero();
    int nw;
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 50, 0);
    tick(hitw(1, 16'sd15500));
    nw = 0;
    repeat (10) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL nsamp_zero writes got=%0d want=0", nw); end
    nsamp = 10'd5;
    tick(hitw(1, 16'sd15500));
    nw = 0;
    repeat (10) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL nsamp_zero_done writes got=%0d want=0", nw); end
    start = 1'b0;
    tickb();
  endtask

  task automatic test_async_reset();
    int nw;
    trigger = 1'b1;
    arm(1'b0, 16'sd15000, 40, 30);
    tick(hitw(1, 16'sd20000));
    repeat (5) tickb();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd43) begin
      errors++;
      $display("FAIL pre_reset_write we=%b addr=%0d want we=1 addr=43", mem_we, mem_addr);
    end
    #1 areset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL async_we got=%b want=0", mem_we); end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL async_addr got=%0d want=0", mem_addr); end
    checks++;
    if (mem_di !== '0) begin errors++; $display("FAIL async_di got=%h want=0", mem_di); end
    @(negedge aclk);
    areset = 1'b0;
    repeat (5) tickb();
    checks++;
    if (mem_di !== '0) begin errors++; $display("FAIL dly_cleared got=%h want=0", mem_di); end
    tick(hitw(2, 16'sd15500));
    nw = 0;
    repeat (25) begin tickb(); if (mem_we === 1'b1) nw++; end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL no_arm_after_reset writes got=%0d want=0", nw); end
    start = 1'b0;
    tickb();
  endtask

  initial begin
    test_reset();
    test_gt_capture();
    test_lt_capture();
    test_no_hit();
    test_abort_rearm();
    test_addr_end();
    test_nsamp_zero();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
